// File: rtl/pa_riscv_pkg.sv
// Shared RV32I control types: opcodes, FSM states, ALU operations, mux selects
// and fault causes for the multi-cycle controller.
package pa_riscv;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BTYPE = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  // STARTUP must stay encoding 0: every output reads 0 while in reset.
  typedef enum logic [3:0] {
    S_STARTUP, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_FAULT
  } e_state;

  typedef enum logic [3:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} e_aluOp;
  typedef enum logic [1:0] {SRCA_PC, SRCA_OLDPC, SRCA_RS1} e_srcA;
  typedef enum logic [1:0] {SRCB_RS2, SRCB_IMM, SRCB_FOUR} e_srcB;
  typedef enum logic [1:0] {RES_ALUOUT, RES_DATA, RES_ALURESULT} e_result;
  typedef enum logic [1:0] {ALUCL_ADD, ALUCL_SUB, ALUCL_FUNCT} e_aluClass;

endpackage

// File: rtl/multi_cycle_controller_alu_decoder.sv
// ALU operation decode and instruction legality check; also used by the
// pipelined core, so it carries no state.
module alu_decoder
  import pa_riscv::*;
#(
  parameter int BNE_EN = 1
) (
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7bit5,
  input  e_aluClass  i_aluOpClass,
  output e_aluOp     o_aluLogicOperation,
  output logic       o_illegal
);

  logic f3_alu_ok;

  always_comb begin
    f3_alu_ok = (i_funct3 == F3_ADD) || (i_funct3 == F3_SLT) ||
                (i_funct3 == F3_OR)  || (i_funct3 == F3_AND);

    o_illegal = 1'b1;
    case (i_opcode)
      OP_LW, OP_SW, OP_JAL: o_illegal = 1'b0;
      OP_RTYPE, OP_ITYPE:   o_illegal = !f3_alu_ok;
      OP_BTYPE:             o_illegal = !((i_funct3 == F3_BEQ) ||
                                          ((BNE_EN != 0) && (i_funct3 == F3_BNE)));
      default:              o_illegal = 1'b1;
    endcase

    o_aluLogicOperation = ALU_ADD;
    case (i_aluOpClass)
      ALUCL_SUB: o_aluLogicOperation = ALU_SUB;
      ALUCL_FUNCT: begin
        case (i_funct3)
          // funct7bit5 on an I-type is an immediate bit, so only R-type subtracts
          F3_ADD:  o_aluLogicOperation = (i_opcode == OP_RTYPE && i_funct7bit5) ? ALU_SUB : ALU_ADD;
          F3_AND:  o_aluLogicOperation = ALU_AND;
          F3_OR:   o_aluLogicOperation = ALU_OR;
          F3_SLT:  o_aluLogicOperation = ALU_SLT;
          default: o_aluLogicOperation = ALU_ADD;
        endcase
      end
      default: o_aluLogicOperation = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences shared memory via
// req/ack, drives datapath enables per state, traps illegal ops and hung accesses.
module multi_cycle_controller
  import pa_riscv::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int BNE_EN         = 1,
  parameter int TOUT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       i_clk,
  input  logic       i_arst,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7bit5,
  input  logic       i_zeroFlag,
  input  logic       i_memAck,
  output logic       o_memReq,
  output logic       o_memWriteEn,
  output logic       o_adrSrc,
  output logic       o_pcWrite,
  output logic       o_irWrite,
  output logic       o_regWriteEn,
  output logic [1:0] o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [1:0] o_resultSel,
  output logic [3:0] o_aluLogicOperation,
  output logic [1:0] o_fault,
  output logic [3:0] o_state
);

  localparam int WD_W = (TOUT_W > 0) ? TOUT_W : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  e_state          state_q, state_d;
  logic [1:0]      fault_q, fault_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            mem_req, timeout, illegal;
  e_aluClass       alu_class;
  e_aluOp          alu_op;

  alu_decoder #(.BNE_EN(BNE_EN)) u_alu_dec (
    .i_opcode            (i_opcode),
    .i_funct3            (i_funct3),
    .i_funct7bit5        (i_funct7bit5),
    .i_aluOpClass        (alu_class),
    .o_aluLogicOperation (alu_op),
    .o_illegal           (illegal)
  );

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= S_STARTUP;
      fault_q <= FAULT_NONE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      wd_q    <= wd_d;
    end
  end

  // Timeout fires on the cycle the count would reach TIMEOUT_CYCLES; a
  // same-cycle ack suppresses it so the access completes normally.
  always_comb begin
    mem_req = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    timeout = (TIMEOUT_CYCLES != 0) && mem_req && !i_memAck && (wd_q == WD_LAST);
    wd_d    = (mem_req && !i_memAck && !timeout) ? wd_q + WD_W'(1) : '0;
  end

  always_comb begin
    state_d      = state_q;
    fault_d      = fault_q;
    alu_class    = ALUCL_ADD;
    o_memReq     = 1'b0;
    o_memWriteEn = 1'b0;
    o_adrSrc     = 1'b0;
    o_pcWrite    = 1'b0;
    o_irWrite    = 1'b0;
    o_regWriteEn = 1'b0;
    o_aluSrcA    = SRCA_PC;
    o_aluSrcB    = SRCB_RS2;
    o_resultSel  = RES_ALUOUT;

    case (state_q)
      S_STARTUP: state_d = S_FETCH;
      S_FETCH: begin
        o_memReq    = 1'b1;
        o_aluSrcA   = SRCA_PC;
        o_aluSrcB   = SRCB_FOUR;
        o_resultSel = RES_ALURESULT;
        o_pcWrite   = i_memAck;
        o_irWrite   = i_memAck;
        if (i_memAck) state_d = S_DECODE;
      end
      S_DECODE: begin
        o_aluSrcA = SRCA_OLDPC;
        o_aluSrcB = SRCB_IMM;
        if (illegal) begin
          state_d = S_FAULT;
          fault_d = FAULT_ILLEGAL;
        end else begin
          case (i_opcode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_EXECR;
            OP_ITYPE:     state_d = S_EXECI;
            OP_BTYPE:     state_d = S_BRANCH;
            OP_JAL:       state_d = S_JAL;
            default: begin
              state_d = S_FAULT;
              fault_d = FAULT_ILLEGAL;
            end
          endcase
        end
      end
      S_MEMADR: begin
        o_aluSrcA = SRCA_RS1;
        o_aluSrcB = SRCB_IMM;
        state_d   = (i_opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        o_memReq = 1'b1;
        o_adrSrc = 1'b1;
        if (i_memAck) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        o_resultSel  = RES_DATA;
        o_regWriteEn = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        o_memReq     = 1'b1;
        o_memWriteEn = 1'b1;
        o_adrSrc     = 1'b1;
        if (i_memAck) state_d = S_FETCH;
      end
      S_EXECR: begin
        o_aluSrcA = SRCA_RS1;
        o_aluSrcB = SRCB_RS2;
        alu_class = ALUCL_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        o_aluSrcA = SRCA_RS1;
        o_aluSrcB = SRCB_IMM;
        alu_class = ALUCL_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        o_resultSel  = RES_ALUOUT;
        o_regWriteEn = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        o_aluSrcA   = SRCA_RS1;
        o_aluSrcB   = SRCB_RS2;
        alu_class   = ALUCL_SUB;
        o_resultSel = RES_ALUOUT;
        o_pcWrite   = i_zeroFlag ^ ((BNE_EN != 0) && (i_funct3 == F3_BNE));
        state_d     = S_FETCH;
      end
      S_JAL: begin
        o_aluSrcA   = SRCA_OLDPC;
        o_aluSrcB   = SRCB_FOUR;
        o_resultSel = RES_ALUOUT;
        o_pcWrite   = 1'b1;
        state_d     = S_ALUWB;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_STARTUP;
    endcase

    if (timeout) begin
      state_d = S_FAULT;
      fault_d = FAULT_TIMEOUT;
    end
  end

  assign o_aluLogicOperation = alu_op;
  assign o_fault             = fault_q;
  assign o_state             = state_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: vector table plus corner-case sequences,
// compared through an expected-value queue; three parameter variants.
module tb_multi_cycle_controller;
  import pa_riscv::*;

  typedef struct packed {
    logic [3:0] st;
    logic       req, we, adr, pcw, irw, rw;
    logic [1:0] sa, sb, rs;
    logic [3:0] op;
    logic [1:0] flt;
  } out_t;

  typedef struct packed {
    logic [10:0] ins;
    logic        zero, ack;
    out_t        exp, msk;
  } vec_t;

  localparam logic [10:0] I_ADDI  = {OP_ITYPE, 3'b000, 1'b0};
  localparam logic [10:0] I_ADDIN = {OP_ITYPE, 3'b000, 1'b1};
  localparam logic [10:0] I_SLTI  = {OP_ITYPE, 3'b010, 1'b0};
  localparam logic [10:0] I_ORI   = {OP_ITYPE, 3'b110, 1'b0};
  localparam logic [10:0] I_SUB   = {OP_RTYPE, 3'b000, 1'b1};
  localparam logic [10:0] I_AND   = {OP_RTYPE, 3'b111, 1'b0};
  localparam logic [10:0] I_LW    = {OP_LW,    3'b010, 1'b0};
  localparam logic [10:0] I_SW    = {OP_SW,    3'b010, 1'b0};
  localparam logic [10:0] I_BEQ   = {OP_BTYPE, 3'b000, 1'b0};
  localparam logic [10:0] I_BNE   = {OP_BTYPE, 3'b001, 1'b0};
  localparam logic [10:0] I_JAL   = {OP_JAL,   3'b000, 1'b0};
  localparam logic [10:0] I_LUI   = {7'b0110111, 3'b000, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opc = '0;
  logic [2:0] f3 = '0;
  logic       f7 = 1'b0, zero = 1'b0, ack = 1'b0;
  out_t       ob [3];

  always #5 clk = ~clk;

  // 0: defaults, 1: BNE_EN=0, 2: TIMEOUT_CYCLES=8
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [3:0] st, op;
    logic       req, we, adr, pcw, irw, rw;
    logic [1:0] sa, sb, rs, flt;
    multi_cycle_controller #(
      .TIMEOUT_CYCLES(g == 2 ? 8 : 256),
      .BNE_EN        (g == 1 ? 0 : 1)
    ) u_dut (
      .i_clk(clk), .i_arst(rst), .i_opcode(opc), .i_funct3(f3), .i_funct7bit5(f7),
      .i_zeroFlag(zero), .i_memAck(ack),
      .o_memReq(req), .o_memWriteEn(we), .o_adrSrc(adr), .o_pcWrite(pcw),
      .o_irWrite(irw), .o_regWriteEn(rw), .o_aluSrcA(sa), .o_aluSrcB(sb),
      .o_resultSel(rs), .o_aluLogicOperation(op), .o_fault(flt), .o_state(st)
    );
    assign ob[g] = {st, req, we, adr, pcw, irw, rw, sa, sb, rs, op, flt};
  end

  out_t sb_exp [$];
  out_t sb_msk [$];
  vec_t tbl [$];
  int   errs = 0;
  int   checks = 0;

  // m masks mux fields {sa,sb,rs,op}; adrSrc is only meaningful while requesting
  function automatic vec_t v(logic [10:0] ins, logic z, logic a, e_state st, logic [5:0] ctl,
                             logic [1:0] sa, logic [1:0] sb, logic [1:0] rs, logic [3:0] op,
                             logic [3:0] m, logic [1:0] flt);
    vec_t r;
    r.ins  = ins;
    r.zero = z;
    r.ack  = a;
    r.exp  = {st, ctl, sa, sb, rs, op, flt};
    r.msk  = {4'hF, 2'b11, ctl[5], 3'b111, {2{m[3]}}, {2{m[2]}}, {2{m[1]}}, {4{m[0]}}, 2'b11};
    return r;
  endfunction

  task automatic check(input int sel, input string name);
    out_t e, m, a;
    e = sb_exp.pop_front();
    m = sb_msk.pop_front();
    a = ob[sel];
    checks++;
    if ((a & m) != (e & m)) begin
      errs++;
      $display("FAIL %s dut%0d: got state=%0d outs=%h, expected state=%0d outs=%h (mask %h)",
               name, sel, a.st, a, e.st, e, m);
    end
  endtask

  task automatic step(input vec_t r, input int sel, input string name);
    @(posedge clk);
    #1;
    {opc, f3, f7} = r.ins;
    zero = r.zero;
    ack  = r.ack;
    sb_exp.push_back(r.exp);
    sb_msk.push_back(r.msk);
    @(negedge clk);
    check(sel, name);
  endtask

  task automatic do_reset(input int sel);
    @(posedge clk);
    #1;
    rst = 1'b1;
    {opc, f3, f7} = '0;
    zero = 1'b0;
    ack  = 1'b0;
    #2;
    sb_exp.push_back('0);
    sb_msk.push_back('1);
    check(sel, "reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic vec_t fetch(logic [10:0] ins, logic a);
    return v(ins, 1'b0, a, S_FETCH, a ? 6'b100110 : 6'b100000,
             SRCA_PC, SRCB_FOUR, RES_ALURESULT, ALU_ADD, 4'b1111, '0);
  endfunction

  function automatic vec_t decode(logic [10:0] ins);
    return v(ins, 1'b0, 1'b0, S_DECODE, '0, SRCA_OLDPC, SRCB_IMM, '0, ALU_ADD, 4'b1101, '0);
  endfunction

  function automatic vec_t exec(logic [10:0] ins, e_state st, logic [1:0] sb, e_aluOp op);
    return v(ins, 1'b0, 1'b0, st, '0, SRCA_RS1, sb, '0, op, 4'b1101, '0);
  endfunction

  function automatic vec_t aluwb(logic [10:0] ins, logic a);
    return v(ins, 1'b0, a, S_ALUWB, 6'b000001, '0, '0, RES_ALUOUT, '0, 4'b0010, '0);
  endfunction

  task automatic push_fd(input logic [10:0] ins);
    tbl.push_back(fetch(ins, 1'b1));
    tbl.push_back(decode(ins));
  endtask

  initial begin
    // addi, ack on first request; acks outside memory states are ignored
    tbl.push_back(fetch(I_ADDI, 1'b1));
    tbl.push_back(v(I_ADDI, 1'b0, 1'b1, S_DECODE, '0, SRCA_OLDPC, SRCB_IMM, '0, ALU_ADD, 4'b1101, '0));
    tbl.push_back(exec(I_ADDI, S_EXECI, SRCB_IMM, ALU_ADD));
    tbl.push_back(aluwb(I_ADDI, 1'b1));
    // lw with ack delayed three cycles on each access
    for (int i = 0; i < 3; i++) tbl.push_back(fetch(I_LW, 1'b0));
    push_fd(I_LW);
    tbl.push_back(v(I_LW, 1'b0, 1'b0, S_MEMADR, '0, SRCA_RS1, SRCB_IMM, '0, ALU_ADD, 4'b1101, '0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(I_LW, 1'b0, 1'b0, S_MEMREAD, 6'b101000, '0, '0, '0, '0, 4'b0000, '0));
    tbl.push_back(v(I_LW, 1'b0, 1'b1, S_MEMREAD, 6'b101000, '0, '0, '0, '0, 4'b0000, '0));
    tbl.push_back(v(I_LW, 1'b0, 1'b0, S_MEMWB, 6'b000001, '0, '0, RES_DATA, '0, 4'b0010, '0));
    // branches
    push_fd(I_BEQ);
    tbl.push_back(v(I_BEQ, 1'b1, 1'b0, S_BRANCH, 6'b000100, SRCA_RS1, SRCB_RS2, RES_ALUOUT, ALU_SUB, 4'b1111, '0));
    push_fd(I_BNE);
    tbl.push_back(v(I_BNE, 1'b1, 1'b0, S_BRANCH, 6'b000000, SRCA_RS1, SRCB_RS2, RES_ALUOUT, ALU_SUB, 4'b1111, '0));
    push_fd(I_BNE);
    tbl.push_back(v(I_BNE, 1'b0, 1'b0, S_BRANCH, 6'b000100, SRCA_RS1, SRCB_RS2, RES_ALUOUT, ALU_SUB, 4'b1111, '0));
    // ALU decode variants
    push_fd(I_SUB);
    tbl.push_back(exec(I_SUB, S_EXECR, SRCB_RS2, ALU_SUB));
    tbl.push_back(aluwb(I_SUB, 1'b0));
    push_fd(I_AND);
    tbl.push_back(exec(I_AND, S_EXECR, SRCB_RS2, ALU_AND));
    tbl.push_back(aluwb(I_AND, 1'b0));
    push_fd(I_SLTI);
    tbl.push_back(exec(I_SLTI, S_EXECI, SRCB_IMM, ALU_SLT));
    tbl.push_back(aluwb(I_SLTI, 1'b0));
    push_fd(I_ORI);
    tbl.push_back(exec(I_ORI, S_EXECI, SRCB_IMM, ALU_OR));
    tbl.push_back(aluwb(I_ORI, 1'b0));
    push_fd(I_ADDIN);
    tbl.push_back(exec(I_ADDIN, S_EXECI, SRCB_IMM, ALU_ADD));
    tbl.push_back(aluwb(I_ADDIN, 1'b0));
    // jal then sw
    push_fd(I_JAL);
    tbl.push_back(v(I_JAL, 1'b0, 1'b0, S_JAL, 6'b000100, SRCA_OLDPC, SRCB_FOUR, RES_ALUOUT, ALU_ADD, 4'b1111, '0));
    tbl.push_back(aluwb(I_JAL, 1'b0));
    push_fd(I_SW);
    tbl.push_back(v(I_SW, 1'b0, 1'b0, S_MEMADR, '0, SRCA_RS1, SRCB_IMM, '0, ALU_ADD, 4'b1101, '0));
    tbl.push_back(v(I_SW, 1'b0, 1'b0, S_MEMWRITE, 6'b111000, '0, '0, '0, '0, 4'b0000, '0));
    tbl.push_back(v(I_SW, 1'b0, 1'b1, S_MEMWRITE, 6'b111000, '0, '0, '0, '0, 4'b0000, '0));
    tbl.push_back(fetch(I_ADDI, 1'b0));

    do_reset(0);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 0, $sformatf("vec%0d", i));

    // lui is illegal; fault is sticky through ack pulses
    do_reset(0);
    step(fetch(I_LUI, 1'b1), 0, "lui_fetch");
    step(decode(I_LUI), 0, "lui_decode");
    for (int i = 0; i < 200; i++)
      step(v(I_LUI, 1'b0, (i % 2 == 0), S_FAULT, '0, '0, '0, '0, '0, 4'b0000, FAULT_ILLEGAL),
           0, $sformatf("lui_fault%0d", i));

    // bne illegal when BNE_EN=0
    do_reset(1);
    step(fetch(I_BNE, 1'b1), 1, "nobne_fetch");
    step(decode(I_BNE), 1, "nobne_decode");
    step(v(I_BNE, 1'b1, 1'b0, S_FAULT, '0, '0, '0, '0, '0, 4'b0000, FAULT_ILLEGAL), 1, "nobne_fault");

    // watchdog with TIMEOUT_CYCLES=8: never acked
    do_reset(2);
    for (int i = 0; i < 8; i++) step(fetch(I_ADDI, 1'b0), 2, $sformatf("wd_fetch%0d", i));
    step(v(I_ADDI, 1'b0, 1'b0, S_FAULT, '0, '0, '0, '0, '0, 4'b0000, FAULT_TIMEOUT), 2, "wd_fault");
    step(v(I_ADDI, 1'b0, 1'b1, S_FAULT, '0, '0, '0, '0, '0, 4'b0000, FAULT_TIMEOUT), 2, "wd_sticky");

    // ack on the timeout cycle wins
    do_reset(2);
    for (int i = 0; i < 7; i++) step(fetch(I_ADDI, 1'b0), 2, $sformatf("wdack_fetch%0d", i));
    step(fetch(I_ADDI, 1'b1), 2, "wdack_fetch7");
    step(decode(I_ADDI), 2, "wdack_decode");

    // async reset while a write is outstanding
    do_reset(0);
    step(fetch(I_SW, 1'b1), 0, "arst_fetch");
    step(decode(I_SW), 0, "arst_decode");
    step(v(I_SW, 1'b0, 1'b0, S_MEMADR, '0, SRCA_RS1, SRCB_IMM, '0, ALU_ADD, 4'b1101, '0), 0, "arst_memadr");
    step(v(I_SW, 1'b0, 1'b0, S_MEMWRITE, 6'b111000, '0, '0, '0, '0, 4'b0000, '0), 0, "arst_memwrite");
    #2;
    rst = 1'b1;
    #1;
    sb_exp.push_back('0);
    sb_msk.push_back('1);
    check(0, "arst_drop");
    @(posedge clk);
    #3;
    rst = 1'b0;
    step(fetch(I_SW, 1'b0), 0, "arst_refetch");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL time_limit: bench did not reach its summary, checks=%0d", checks);
    $fatal(1, "time limit");
  end

endmodule
